multdiv_ctrl: RTL
=================

// Module: multdiv_ctrl
// PURPOSE
//   Sequencer for signed 32-bit multiply and divide that time-shares one external 32-bit
//   add/sub unit (sub input, 32-bit sum, overflow flag) instead of instantiating its own.
//   Sits beside the ALU in the execute stage; the processor pulses a start, stalls, and
//   waits for result_ready. One adder operation is issued per cycle; the adder is purely combinational.
// PARAMETERS
//   ITER   32  number of shift/add iterations (equal to the operand width; fixed at 32)
// PORTS
//   clock         in   1   rising-edge clock
//   reset         in   1   asynchronous, active-high reset
//   ctrl_mult     in   1   one-cycle start pulse: data_a * data_b (signed)
//   ctrl_div      in   1   one-cycle start pulse: data_a / data_b (signed, quotient truncates toward 0)
//   data_a        in   32  operand A; sampled only on the start edge
//   data_b        in   32  operand B; sampled only on the start edge
//   add_sub       out  1   to shared adder: 1 = x - y, 0 = x + y
//   add_x         out  32  to shared adder: operand x
//   add_y         out  32  to shared adder: operand y (the adder inverts y itself when add_sub=1)
//   add_s         in   32  from shared adder: sum/difference, same cycle
//   add_ovf       in   1   from shared adder: signed overflow (informational; not used for exception)
//   result        out  32  low 32 bits of product, or quotient
//   exception     out  1   mult: product does not fit in 32 bits signed; div: divide by zero
//   result_ready  out  1   one-cycle pulse; result/exception are valid from this cycle on
//   busy          out  1   high from the cycle after the start edge until DONE exits
// BEHAVIOUR
//   Reset: state=IDLE; result, exception, result_ready, busy, add_* all 0; counter 0.
//     Reset mid-operation aborts immediately; no result_ready pulse is produced.
//   States: IDLE, MULT, NEGA, NEGB, DIV, FIX, DONE.
//   Start: sampled only in IDLE. If both pulses are high, ctrl_mult wins.
//     Starts while not in IDLE (including DONE) are ignored.
//   Edge numbering: E0 is the edge that samples the start; En is n edges later.
//   MULT: radix-2 Booth algorithm over a 65-bit register {hi[31:0], lo[31:0], q-1}.
//     Each cycle:
//       bits 01 -> add_sub=0, x=hi, y=B
//       bits 10 -> add_sub=1, x=hi, y=B
//       bits 00/11 -> x=hi, y=0
//     hi <= add_s, then arithmetic shift right by 1. The counter decrements from 31 to 0.
//     DONE is entered at E32; result_ready is high for the cycle between E32 and E33.
//     exception=1 iff hi is not 32 copies of lo[31].
//   DIV:
//     B==0 at E0 -> DONE at E1, result=0, exception=1.
//     Otherwise:
//       NEGA (adder: 0-A if A<0, else passes A via 0+A) -> |A|
//       NEGB (same for B) -> |B|
//       DIV: 32 restoring iterations. remainder R is 33 bits, compared via R-|B| on the adder.
//         If the difference is >=0 (adder borrow clear): keep the difference, quotient bit=1.
//         Otherwise: restore R, quotient bit=0.
//       FIX: if sign(A)^sign(B), quotient <= 0 - quotient through the adder.
//     DONE is entered at E35. exception=0. A=0x80000000, B=-1 gives result 0x80000000, exception=0.
//   DONE: lasts 1 cycle, then IDLE. result and exception hold until the next accepted start,
//     which clears exception at E0.
//   add_* are driven to 0 in IDLE and DONE. The controller never reads add_s in those states.
//   busy=0 in IDLE; busy=1 in every other state, including DONE.
// CONFIGURATION
//   MULTDIV_EARLY_EXIT_EN defined:
//     - ctrl_mult with data_a==0 or data_b==0 skips iteration: DONE at E1, result=0, exception=0.
//     - Divide with data_a==0 also exits at E1 with result=0.
//   MULTDIV_EARLY_EXIT_EN undefined: every multiply takes 32 iterations (DONE at E32), and a
//     divide with A==0 runs the full 35-cycle path. Results are identical either way;
//     only latency differs.
// TESTING
//   mult 7 * -3                  -> result_ready in cycle after E32; result=0xFFFFFFEB, exception=0
//   mult 0x00010000 * 0x00010000 -> result=0x00000000, exception=1 (product 2^32 overflows)
//   div -100 / 7                 -> DONE at E35; result=0xFFFFFFF2 (-14), exception=0
//   div 5 / 0                    -> result_ready in cycle after E1; result=0, exception=1
//   ctrl_mult and ctrl_div high together, then ctrl_div pulsed at E5 -> multiply executes;
//     E5 pulse ignored; exactly one result_ready pulse
//   reset asserted at E10 of a divide -> busy=0 and result=0 immediately; no result_ready;
//     a new mult 3*4 then returns 12
//   MULTDIV_EARLY_EXIT_EN: mult 0 * 123 -> result_ready in cycle after E1; without the macro,
//     in cycle after E32; both give result=0

Source files
------------

// File: rtl/multdiv_ctrl.sv
// Signed 32x32 multiply / 32/32 divide sequencer driving a shared external add/sub unit.
// Optional MULTDIV_EARLY_EXIT_EN: zero operands finish one cycle after the start edge.
module multdiv_ctrl #(
    parameter int unsigned ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_mult,
    input  logic        ctrl_div,
    input  logic [31:0] data_a,
    input  logic [31:0] data_b,
    output logic        add_sub,
    output logic [31:0] add_x,
    output logic [31:0] add_y,
    input  logic [31:0] add_s,
    input  logic        add_ovf,
    output logic [31:0] result,
    output logic        exception,
    output logic        result_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, MULT, NEGA, NEGB, DIV, FIX, DONE
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;       // Booth high half / division remainder
    logic [31:0] lo_q, lo_d;       // Booth low half / dividend, then quotient
    logic        qm1_q, qm1_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] result_q, result_d;
    logic        exc_q, exc_d;

    logic        sgn;
    logic [32:0] r_sh;
    logic        borrow;
    logic        ge;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            b_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        exc_d    = exc_q;
        add_sub  = 1'b0;
        add_x    = '0;
        add_y    = '0;
        sgn      = 1'b0;
        r_sh     = '0;
        borrow   = 1'b0;
        ge       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ctrl_mult) begin
                    hi_d    = '0;
                    lo_d    = data_a;
                    qm1_d   = 1'b0;
                    b_d     = data_b;
                    cnt_d   = CNT_LAST;
                    exc_d   = 1'b0;
                    state_d = MULT;
                end else if (ctrl_div) begin
                    hi_d    = '0;
                    lo_d    = data_a;
                    b_d     = data_b;
                    neg_d   = data_a[31] ^ data_b[31];
                    exc_d   = 1'b0;
                    state_d = NEGA;
                end
            end
            MULT: begin
                add_x = hi_q;
                unique case ({lo_q[0], qm1_q})
                    2'b01: add_y = b_q;
                    2'b10: begin
                        add_sub = 1'b1;
                        add_y   = b_q;
                    end
                    default: add_y = '0;
                endcase
                // True sign of hi+-B even when the 32-bit sum overflows (B = -2^31).
                sgn   = add_s[31] ^ add_ovf;
                hi_d  = {sgn, add_s[31:1]};
                lo_d  = {add_s[0], lo_q[31:1]};
                qm1_d = lo_q[0];
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d  = DONE;
                    result_d = lo_d;
                    exc_d    = (hi_d != {32{lo_d[31]}});
                end
`ifdef MULTDIV_EARLY_EXIT_EN
                if (cnt_q == CNT_LAST && (lo_q == '0 || b_q == '0)) begin
                    state_d  = DONE;
                    result_d = '0;
                    exc_d    = 1'b0;
                end
`endif
            end
            NEGA: begin
                add_sub = lo_q[31];
                add_y   = lo_q;
                lo_d    = add_s;
                state_d = NEGB;
                if (b_q == '0) begin
                    state_d  = DONE;
                    result_d = '0;
                    exc_d    = 1'b1;
                end
`ifdef MULTDIV_EARLY_EXIT_EN
                else if (lo_q == '0) begin
                    state_d  = DONE;
                    result_d = '0;
                    exc_d    = 1'b0;
                end
`endif
            end
            NEGB: begin
                add_sub = b_q[31];
                add_y   = b_q;
                b_d     = add_s;
                hi_d    = '0;
                cnt_d   = CNT_LAST;
                state_d = DIV;
            end
            DIV: begin
                r_sh    = {hi_q, lo_q[31]};
                add_sub = 1'b1;
                add_x   = r_sh[31:0];
                add_y   = b_q;
                // Unsigned borrow of x - |B| recovered from the sum and the operand MSBs.
                borrow  = (add_x[31] == add_y[31]) ? add_s[31] : add_y[31];
                ge      = r_sh[32] | ~borrow;
                hi_d    = ge ? add_s : r_sh[31:0];
                lo_d    = {lo_q[30:0], ge};
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                add_sub  = neg_q;
                add_y    = lo_q;
                result_d = add_s;
                exc_d    = 1'b0;
                state_d  = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign result       = result_q;
    assign exception    = exc_q;
    assign result_ready = (state_q == DONE);
    assign busy         = (state_q != IDLE);

endmodule
